// File: rtl/subtractor_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: state encoding and
// the width of the bit counter.
package subtractor_serial_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

   // The counter must be able to hold N so that it cannot wrap within one operation.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/subtractor_serial_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface subtractor_serial_if #(parameter int N = 4);

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bi;
   logic         busy;
   logic         done;
   logic [N-1:0] d;
   logic         bo;
   logic         ov;

   modport master (output start, a, b, bi, input busy, done, d, bo, ov);
   modport slave  (input start, a, b, bi, output busy, done, d, bo, ov);

endinterface

// File: rtl/subtractor_serial_fs.sv
// One-bit full subtractor: d = a - b - bi with borrow-out bo.
module fs (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial N-bit subtractor: one full-subtractor cell walks the operands
// LSB first, one bit per clock, behind a start/done handshake.
module subtractor_serial
   import subtractor_serial_pkg::*;
#(
   parameter int N = 4
) (
   input  logic              clock,
   input  logic              reset,
   subtractor_serial_if.slave bus
);

   localparam int CW = cnt_width(N);

   state_t        state;
   logic [N-1:0]  sa;
   logic [N-1:0]  sb;
   logic          br;
   logic          msb_a;
   logic          msb_b;
   logic [CW-1:0] cnt;
   logic          busy_r;
   logic          done_r;
   logic [N-1:0]  d_r;
   logic          bo_r;
   logic          ov_r;

   logic          diff;
   logic          br_next;
   logic [N-1:0]  d_next;

   fs u_fs (
      .a  (sa[0]),
      .b  (sb[0]),
      .bi (br),
      .d  (diff),
      .bo (br_next)
   );

   // New difference bit enters from the MSB side; written this way so N = 1 also works.
   always_comb begin
      d_next        = d_r >> 1;
      d_next[N-1]   = diff;
   end

   // Single FSM block; all handshake and result outputs are registered here.
   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         sa     <= '0;
         sb     <= '0;
         br     <= 1'b0;
         msb_a  <= 1'b0;
         msb_b  <= 1'b0;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         d_r    <= '0;
         bo_r   <= 1'b0;
         ov_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa     <= bus.a;
                  sb     <= bus.b;
                  br     <= bus.bi;
                  msb_a  <= bus.a[N-1];
                  msb_b  <= bus.b[N-1];
                  cnt    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               br  <= br_next;
               d_r <= d_next;
               cnt <= cnt + CW'(1);
               // On the last bit diff is the new result MSB, so ov can be formed here.
               if (cnt == CW'(N - 1)) begin
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  bo_r   <= br_next;
                  ov_r   <= (msb_a ^ msb_b) & (diff ^ msb_a);
                  state  <= DONE;
               end
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.d    = d_r;
   assign bus.bo   = bo_r;
   assign bus.ov   = ov_r;

endmodule
